jtpang_eeprom93: RTL and testbench
==================================

JTPANG_EEPROM93 -- requirements
Module: jtpang_eeprom93

Interface
REQ-001 SHALL have parameter WR_DLY, default 1024, meaning clk cycles a serial program/erase stays busy.
REQ-002 SHALL have parameter SIMFILE, default "", meaning initial contents file (simulation only).
REQ-003 SHALL have port clk  in  1  system clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port scs  in  1  serial chip select, active-high, driven by the CPU latch.
REQ-006 SHALL have port sclk  in  1  serial clock from the CPU latch, asynchronous to clk protocol-wise.
REQ-007 SHALL have port sdi  in  1  serial data into the EEPROM.
REQ-008 SHALL have port sdo  out  1  serial data/ready out to the CPU status byte.
REQ-009 SHALL have ports dump_addr  in  7, dump_din  in  8, dump_we  in  1, dump_dout  out  8: byte-wide NVRAM dump/restore port (see REQ-028).

Function
REQ-010 SHALL model a 93C46 in x16 mode: 64 words x 16 bits, MSB first on the wire.
REQ-011 SHALL detect sclk rising edges as a 0->1 change between consecutive clk samples; sdi is sampled on that same clk cycle.
REQ-012 SHALL use states IDLE, CMD, RDATA, WDATA, BUSY, WAITLOW.
REQ-013 SHALL, in IDLE with scs=1, stay idle until an sclk edge with sdi=1 (start bit), then go to CMD; leading zeros ignored.
REQ-014 SHALL, in CMD, shift 8 bits (opcode[1:0], addr[5:0]); after the 8th edge decode: 10 READ->RDATA; 01 WRITE->WDATA; 11 ERASE->BUSY; 00 with addr[5:4]=11 EWEN, =00 EWDS, =10 ERAL->BUSY, =01 WRAL->WDATA.
REQ-015 SHALL, for EWEN/EWDS, set/clear the write-enable flag and go to WAITLOW; flag reset value is 0.
REQ-016 SHALL, in RDATA, drive sdo=0 (dummy bit) once the address's last bit is taken, then present word bits 15..0 on successive sclk edges; after bit 0 the address increments mod 64 and output continues (sequential read).
REQ-017 SHALL, in WDATA, shift 16 bits; on the 16th edge commit WRITE to addr (WRAL to all 64 words) only if write-enable=1, then enter BUSY; if disabled go to WAITLOW with no change.
REQ-018 SHALL implement ERASE as writing 16'hFFFF to addr and ERAL as 16'hFFFF to all words, both gated by write-enable.
REQ-019 SHALL hold BUSY for WR_DLY clk cycles; while BUSY and scs=1, sdo=0; after expiry sdo=1 while scs=1, state WAITLOW.
REQ-020 SHALL abort any state to IDLE when scs is 0 for a clk sample, without committing partial writes; BUSY countdown continues regardless of scs and new commands are ignored until it expires.
REQ-021 SHALL drive sdo=1 whenever scs=0 or in IDLE/CMD/WAITLOW-not-busy.
REQ-022 SHALL give dump_dout the memory byte at dump_addr (bit 0 selects low/high byte) one clk after the address.
REQ-023 SHALL give a serial commit priority over a dump_we in the same cycle; the dump write is dropped.

Reset
REQ-024 SHALL on rst set state IDLE, sdo=1, write-enable=0, busy counter 0, shift registers 0.
REQ-025 SHALL never clear memory on rst; reset mid-write or mid-BUSY leaves memory in its pre-commit or post-commit state (no partial words).

Configuration
REQ-026 SHALL compile the dump port only when JTPANG_EEPROM_DUMP_EN is defined.
REQ-027 SHALL, without the macro, tie dump_dout to 8'h00 and ignore dump_we/dump_addr/dump_din.
REQ-028 SHALL, with the macro, write dump_din into the addressed byte on dump_we=1.

Structure
REQ-029 SHALL place the opcode constants, extended-address codes and state enum in package jtpang_eeprom_pkg.
REQ-030 SHALL instantiate one sub-module jtpang_eeprom_ram: 64x16 dual-port, port A 16-bit serial side, port B byte side for dump.

Verification
REQ-031 SHALL test EWEN, WRITE addr 5 data 16'hA55A, poll sdo 0 then 1 after WR_DLY, READ addr 5 -> dummy 0 then 16'hA55A.
REQ-032 SHALL test WRITE without EWEN -> READ returns prior value (16'hFFFF after ERAL).
REQ-033 SHALL test READ addr 63 for 32 bits -> word 63 then word 0 (wrap).
REQ-034 SHALL test scs dropped after 9 of 16 write bits -> no change at addr.
REQ-035 SHALL test dump_we addr 7'h0B data 8'h3C -> serial READ addr 5 high byte 8'h3C (macro defined); dump_dout=0 when undefined.
REQ-036 SHALL test rst asserted mid-BUSY -> sdo=1, IDLE, committed word readable.

Source files
------------

// File: rtl/jtpang_eeprom_pkg.sv
// jtpang_eeprom_pkg: 93C46 opcodes, extended-address codes and FSM states.
package jtpang_eeprom_pkg;
  localparam logic [1:0] OP_EXT   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ERASE = 2'b11;
  localparam logic [1:0] EX_EWDS  = 2'b00;
  localparam logic [1:0] EX_WRAL  = 2'b01;
  localparam logic [1:0] EX_ERAL  = 2'b10;
  localparam logic [1:0] EX_EWEN  = 2'b11;
  typedef enum logic [2:0] {IDLE, CMD, RDATA, WDATA, BUSY, WAITLOW} state_t;
endpackage

// File: rtl/jtpang_eeprom_ram.sv
// jtpang_eeprom_ram: 64x16 storage; port A word/all-word side, port B byte side.
module jtpang_eeprom_ram (
  input  logic        clk,
  input  logic        i_a_we,
  input  logic        i_a_all,
  input  logic [5:0]  i_a_addr,
  input  logic [15:0] i_a_din,
  output logic [15:0] o_a_dout,
  input  logic        i_b_we,
  input  logic [6:0]  i_b_addr,
  input  logic [7:0]  i_b_din,
  output logic [7:0]  o_b_dout
);
  logic [15:0] w_mem [64];
  for (genvar w = 0; w < 64; w++) begin : g_word
    logic [15:0] r_word;
    assign w_mem[w] = r_word;
    // A serial commit wins; a byte write in the same cycle is dropped
    always_ff @(posedge clk)
      if (i_a_we) begin
        if (i_a_all || i_a_addr == 6'(w)) r_word <= i_a_din;
      end else if (i_b_we && i_b_addr[6:1] == 6'(w)) begin
        if (i_b_addr[0]) r_word[15:8] <= i_b_din;
        else r_word[7:0] <= i_b_din;
      end
  end
  assign o_a_dout = w_mem[i_a_addr];
  always_ff @(posedge clk)
    o_b_dout <= i_b_addr[0] ? w_mem[i_b_addr[6:1]][15:8] : w_mem[i_b_addr[6:1]][7:0];
endmodule

// File: rtl/jtpang_eeprom93.sv
// jtpang_eeprom93: 93C46 serial EEPROM (x16) with busy/ready signalling.
// Byte dump/restore port is live only when JTPANG_EEPROM_DUMP_EN is defined.
module jtpang_eeprom93
  import jtpang_eeprom_pkg::*;
#(
  parameter int    WR_DLY  = 1024,
  parameter string SIMFILE = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scs,
  input  logic       sclk,
  input  logic       sdi,
  output logic       sdo,
  input  logic [6:0] dump_addr,
  input  logic [7:0] dump_din,
  input  logic       dump_we,
  output logic [7:0] dump_dout
);
  localparam int BW = $clog2(WR_DLY + 1);
  // Contents preload is left to simulation wrappers
  localparam string simfile_unused = SIMFILE;
  state_t r_state, w_next;
  logic          r_sclk, r_wen, r_all, r_dout;
  logic [4:0]    r_cnt;
  logic [7:0]    r_cmd;
  logic [5:0]    r_addr;
  logic [15:0]   r_data;
  logic [BW-1:0] r_busy;
  logic          w_edge, w_we, w_all, w_bwe;
  logic [7:0]    w_cmd, w_bdin, w_bdout;
  logic [6:0]    w_baddr;
  logic [5:0]    w_aaddr;
  logic [15:0]   w_wdat, w_din, w_adout, w_word;
  assign w_edge  = scs & sclk & ~r_sclk;
  assign w_cmd   = {r_cmd[6:0], sdi};
  assign w_wdat  = {r_data[14:0], sdi};
  assign w_aaddr = (r_state == CMD) ? w_cmd[5:0] : r_addr;
  assign w_word  = (r_cnt == 5'd0) ? w_adout : r_data;
  assign sdo     = ~scs | ((r_state == RDATA) ? r_dout : (r_busy == '0));
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_we   = 1'b0;
    w_all  = 1'b0;
    w_din  = 16'hFFFF;
    if (!scs) w_next = IDLE;
    else case (r_state)
      IDLE:  if (w_edge && sdi && r_busy == '0) w_next = CMD;
      CMD:   if (w_edge && r_cnt == 5'd7) begin
        if (w_cmd[7:6] == OP_READ) w_next = RDATA;
        else if (w_cmd[7:6] == OP_WRITE || w_cmd[7:4] == {OP_EXT, EX_WRAL}) w_next = WDATA;
        else if (w_cmd[7:6] == OP_ERASE || w_cmd[7:4] == {OP_EXT, EX_ERAL}) begin
          w_next = r_wen ? BUSY : WAITLOW;
          w_we   = r_wen;
          w_all  = w_cmd[7:6] == OP_EXT;
        end else w_next = WAITLOW;
      end
      WDATA: if (w_edge && r_cnt == 5'd15) begin
        w_next = r_wen ? BUSY : WAITLOW;
        w_we   = r_wen;
        w_all  = r_all;
        w_din  = w_wdat;
      end
      BUSY:  if (r_busy < BW'(2)) w_next = WAITLOW;
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sclk <= 1'b0;
      r_wen  <= 1'b0;
      r_all  <= 1'b0;
      r_dout <= 1'b0;
      r_cnt  <= '0;
      r_cmd  <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_busy <= '0;
    end else begin
      r_sclk <= sclk;
      r_busy <= w_we ? BW'(WR_DLY) : (r_busy != '0 ? r_busy - 1'b1 : r_busy);
      if (r_state == IDLE) r_cnt <= '0;
      else if (w_edge) case (r_state)
        CMD: begin
          r_cmd  <= w_cmd;
          r_addr <= w_cmd[5:0];
          r_all  <= w_cmd[7:4] == {OP_EXT, EX_WRAL};
          r_dout <= 1'b0;
          r_cnt  <= (r_cnt == 5'd7) ? 5'd0 : r_cnt + 5'd1;
          if (r_cnt == 5'd7 && w_cmd[7:4] == {OP_EXT, EX_EWEN}) r_wen <= 1'b1;
          if (r_cnt == 5'd7 && w_cmd[7:4] == {OP_EXT, EX_EWDS}) r_wen <= 1'b0;
        end
        RDATA: begin
          r_dout <= w_word[15];
          r_data <= {w_word[14:0], 1'b0};
          r_cnt  <= (r_cnt == 5'd0) ? 5'd15 : r_cnt - 5'd1;
          if (r_cnt == 5'd1) r_addr <= r_addr + 6'd1;
        end
        WDATA: begin
          r_data <= w_wdat;
          r_cnt  <= r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
`ifdef JTPANG_EEPROM_DUMP_EN
  assign w_bwe     = dump_we;
  assign w_baddr   = dump_addr;
  assign w_bdin    = dump_din;
  assign dump_dout = w_bdout;
`else
  logic w_unused_dump;
  assign w_bwe         = 1'b0;
  assign w_baddr       = '0;
  assign w_bdin        = '0;
  assign dump_dout     = 8'h00;
  assign w_unused_dump = ^{dump_addr, dump_din, dump_we, w_bdout};
`endif
  jtpang_eeprom_ram u_ram (
    .clk      (clk),
    .i_a_we   (w_we),
    .i_a_all  (w_all),
    .i_a_addr (w_aaddr),
    .i_a_din  (w_din),
    .o_a_dout (w_adout),
    .i_b_we   (w_bwe),
    .i_b_addr (w_baddr),
    .i_b_din  (w_bdin),
    .o_b_dout (w_bdout)
  );
endmodule

// File: tb/tb_jtpang_eeprom93.sv
// tb_jtpang_eeprom93: drives the 93C46 serial protocol and checks against a word-array model.
module tb_jtpang_eeprom93;
  localparam int DLY = 40;
  logic clk = 1'b0;
  logic rst, scs, sclk, sdi, dump_we;
  logic sdo;
  logic [6:0] dump_addr;
  logic [7:0] dump_din, dump_dout;
  int checks = 0, failures = 0;
  logic [15:0] model [64];
  bit wen;
  logic last_o, r_first, r_dummy;
  int r_n;
  logic [15:0] got [2];

  jtpang_eeprom93 #(.WR_DLY(DLY)) dut (
    .clk(clk), .rst(rst), .scs(scs), .sclk(sclk), .sdi(sdi), .sdo(sdo),
    .dump_addr(dump_addr), .dump_din(dump_din), .dump_we(dump_we), .dump_dout(dump_dout)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sbit(input logic b);
    sdi = b; tick(2);
    sclk = 1'b1; tick(2);
    last_o = sdo;
    sclk = 1'b0; tick(2);
  endtask

  task automatic desel();
    scs = 1'b0; sdi = 1'b0; tick(3);
  endtask

  task automatic cmd(input logic [1:0] op, input logic [5:0] a);
    logic [7:0] c;
    c = {op, a};
    scs = 1'b1; tick(2);
    sbit(1'b0);
    sbit(1'b1);
    for (int i = 7; i >= 0; i--) sbit(c[i]);
  endtask

  // Issues a command (plus optional 16 data bits), then polls ready
  task automatic wr_op(input logic [1:0] op, input logic [5:0] a, input logic [15:0] d, input bit has_data);
    cmd(op, a);
    if (has_data) for (int i = 15; i >= 0; i--) sbit(d[i]);
    r_first = last_o;
    r_n = 0;
    while (sdo !== 1'b1 && r_n < DLY + 20) begin tick(1); r_n++; end
    desel();
  endtask

  task automatic rd_op(input logic [5:0] a, input int nw);
    cmd(2'b10, a);
    r_dummy = last_o;
    for (int k = 0; k < nw; k++) begin
      got[k] = '0;
      for (int i = 0; i < 16; i++) begin sbit(1'b0); got[k] = {got[k][14:0], last_o}; end
    end
    desel();
  endtask

  task automatic test_reset();
    rst = 1'b1; scs = 1'b0; sclk = 1'b0; sdi = 1'b0;
    dump_we = 1'b0; dump_addr = '0; dump_din = '0;
    tick(3);
    checks++; if (sdo !== 1'b1) begin failures++; $display("FAIL reset_sdo got=%b exp=1", sdo); end
    rst = 1'b0; tick(2);
    scs = 1'b1; tick(2);
    checks++; if (sdo !== 1'b1) begin failures++; $display("FAIL idle_sdo got=%b exp=1", sdo); end
    scs = 1'b0; tick(2);
    wen = 1'b0;
  endtask

  task automatic test_write_read();
    wr_op(2'b00, 6'b110000, 16'h0, 1'b0);
    wen = 1'b1;
    checks++; if (r_first !== 1'b1) begin failures++; $display("FAIL ewen_ready got=%b exp=1", r_first); end
    wr_op(2'b00, 6'b100000, 16'h0, 1'b0);
    for (int i = 0; i < 64; i++) model[i] = 16'hFFFF;
    checks++; if (r_first !== 1'b0 || r_n < DLY - 10 || r_n > DLY) begin
      failures++; $display("FAIL eral_busy first=%b cycles=%0d exp first=0 cycles~%0d", r_first, r_n, DLY); end
    wr_op(2'b01, 6'd5, 16'hA55A, 1'b1);
    model[5] = 16'hA55A;
    checks++; if (r_first !== 1'b0 || r_n < DLY - 10 || r_n > DLY) begin
      failures++; $display("FAIL write_busy first=%b cycles=%0d exp first=0 cycles~%0d", r_first, r_n, DLY); end
    rd_op(6'd5, 1);
    checks++; if (r_dummy !== 1'b0) begin failures++; $display("FAIL read_dummy got=%b exp=0", r_dummy); end
    checks++; if (got[0] !== 16'hA55A) begin failures++; $display("FAIL read5 got=%h exp=a55a", got[0]); end
  endtask

  task automatic test_protect();
    logic [15:0] d;
    d = 16'($urandom);
    wr_op(2'b00, 6'b000000, 16'h0, 1'b0);
    wen = 1'b0;
    wr_op(2'b01, 6'd9, d, 1'b1);
    checks++; if (r_first !== 1'b1) begin failures++; $display("FAIL wp_write_ready got=%b exp=1", r_first); end
    wr_op(2'b11, 6'd5, 16'h0, 1'b0);
    wr_op(2'b00, 6'b010000, d, 1'b1);
    rd_op(6'd9, 1);
    checks++; if (got[0] !== model[9]) begin failures++; $display("FAIL wp_read9 got=%h exp=%h", got[0], model[9]); end
    rd_op(6'd5, 1);
    checks++; if (got[0] !== model[5]) begin failures++; $display("FAIL wp_read5 got=%h exp=%h", got[0], model[5]); end
    wr_op(2'b00, 6'b110000, 16'h0, 1'b0);
    wen = 1'b1;
  endtask

  task automatic test_wrap();
    logic [15:0] a, b;
    a = 16'($urandom); b = 16'($urandom);
    wr_op(2'b01, 6'd63, a, 1'b1); model[63] = a;
    wr_op(2'b01, 6'd0, b, 1'b1);  model[0] = b;
    rd_op(6'd63, 2);
    checks++; if (got[0] !== model[63]) begin failures++; $display("FAIL wrap_w63 got=%h exp=%h", got[0], model[63]); end
    checks++; if (got[1] !== model[0]) begin failures++; $display("FAIL wrap_w0 got=%h exp=%h", got[1], model[0]); end
  endtask

  task automatic test_abort();
    logic [15:0] d;
    d = ~model[12];
    cmd(2'b01, 6'd12);
    for (int i = 15; i >= 7; i--) sbit(d[i]);
    desel();
    rd_op(6'd12, 1);
    checks++; if (got[0] !== model[12]) begin failures++; $display("FAIL abort_read got=%h exp=%h", got[0], model[12]); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int op;
      logic [5:0] a;
      logic [15:0] d;
      op = int'($urandom_range(0, 9));
      a = 6'($urandom); d = 16'($urandom);
      if (op == 0) begin
        wen = $urandom_range(0, 3) != 0;
        wr_op(2'b00, wen ? 6'b110000 : 6'b000000, 16'h0, 1'b0);
      end else if (op <= 3 || op == 9) begin
        if (op == 9) begin
          wr_op(2'b00, 6'b010000, d, 1'b1);
          if (wen) for (int i = 0; i < 64; i++) model[i] = d;
        end else if (op == 3) begin
          wr_op(2'b11, a, 16'h0, 1'b0);
          if (wen) model[a] = 16'hFFFF;
        end else begin
          wr_op(2'b01, a, d, 1'b1);
          if (wen) model[a] = d;
        end
        checks++; if (r_first !== !wen || r_n > DLY) begin
          failures++; $display("FAIL rnd_busy op=%0d first=%b cycles=%0d exp first=%b", op, r_first, r_n, !wen); end
      end else begin
        rd_op(a, 2);
        checks++; if (r_dummy !== 1'b0 || got[0] !== model[a] || got[1] !== model[a + 6'd1]) begin
          failures++; $display("FAIL rnd_read a=%0d got=%h %h exp=%h %h", a, got[0], got[1], model[a], model[a + 6'd1]); end
      end
    end
    wr_op(2'b00, 6'b110000, 16'h0, 1'b0);
    wen = 1'b1;
  endtask

  task automatic test_dump();
    dump_addr = 7'h0B; dump_din = 8'h3C; dump_we = 1'b1;
    tick(1);
    dump_we = 1'b0;
    tick(1);
`ifdef JTPANG_EEPROM_DUMP_EN
    model[5][15:8] = 8'h3C;
    checks++; if (dump_dout !== 8'h3C) begin failures++; $display("FAIL dump_hi got=%h exp=3c", dump_dout); end
    dump_addr = 7'h0A; tick(2);
    checks++; if (dump_dout !== model[5][7:0]) begin failures++; $display("FAIL dump_lo got=%h exp=%h", dump_dout, model[5][7:0]); end
`else
    checks++; if (dump_dout !== 8'h00) begin failures++; $display("FAIL dump_off got=%h exp=00", dump_dout); end
`endif
    rd_op(6'd5, 1);
    checks++; if (got[0] !== model[5]) begin failures++; $display("FAIL dump_read5 got=%h exp=%h", got[0], model[5]); end
  endtask

  task automatic test_reset_busy();
    logic [15:0] d;
    d = ~model[20];
    cmd(2'b01, 6'd20);
    for (int i = 15; i >= 0; i--) sbit(d[i]);
    model[20] = d;
    checks++; if (last_o !== 1'b0) begin failures++; $display("FAIL rb_busy got=%b exp=0", last_o); end
    tick(5);
    rst = 1'b1; tick(2);
    checks++; if (sdo !== 1'b1) begin failures++; $display("FAIL rb_rst_sdo got=%b exp=1", sdo); end
    rst = 1'b0; tick(2);
    checks++; if (sdo !== 1'b1) begin failures++; $display("FAIL rb_idle_sdo got=%b exp=1", sdo); end
    desel();
    wen = 1'b0;
    rd_op(6'd20, 1);
    checks++; if (got[0] !== model[20]) begin failures++; $display("FAIL rb_read got=%h exp=%h", got[0], model[20]); end
    wr_op(2'b01, 6'd20, ~d, 1'b1);
    checks++; if (r_first !== 1'b1) begin failures++; $display("FAIL rb_wen_cleared got=%b exp=1", r_first); end
    rd_op(6'd20, 1);
    checks++; if (got[0] !== model[20]) begin failures++; $display("FAIL rb_read2 got=%h exp=%h", got[0], model[20]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_protect();
    test_wrap();
    test_abort();
    test_random();
    test_dump();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
